lbp_image_host: RTL and testbench
=================================

// Module: lbp_image_host
// PURPOSE
//  Responder/host end of the LBP gray-read / lbp-write interface. Holds the 2^(2*LOG2_DIM) x 8 gray image,
//  serves initiator pixel reads with zero-latency data, captures LBP result writes into a result memory,
//  flags protocol errors, and exposes the result image through a readback port once finish is seen.
// PARAMETERS
//  LOG2_DIM   7   log2 of image width = height; address = {y, x}, ADDR_W = 2*LOG2_DIM (14)
//  DATA_W     8   pixel / LBP code width
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  load_valid  in   1       host pixel-load strobe (raster order, address implicit from 0)
//  load_data   in   DATA_W  pixel to load
//  load_ready  out  1       high in LOAD; beat accepted when load_valid && load_ready
//  gray_addr   in   ADDR_W  initiator read address {y, x}
//  gray_req    in   1       initiator read request
//  gray_ready  out  1       level: image loaded, initiator may start (high only in SERVE)
//  gray_data   out  DATA_W  combinational: gray_req ? gray_mem[gray_addr] : 0
//  lbp_addr    in   ADDR_W  result write address {y, x}
//  lbp_valid   in   1       result write strobe
//  lbp_data    in   DATA_W  result value
//  finish      in   1       initiator done
//  rd_en       in   1       result readback request (DONE only)
//  rd_addr     in   ADDR_W  readback address
//  rd_data     out  DATA_W  lbp_mem[rd_addr], registered
//  rd_valid    out  1       pulses 1 cycle after accepted rd_en
//  done        out  1       high in DONE
//  wr_count    out  ADDR_W+1 number of stored result writes
//  err_border  out  1       sticky: write to x or y == 0 or 2^LOG2_DIM-1
//  err_dup     out  1       sticky: second write to an already-written address
//  err_proto   out  1       sticky: gray_req or lbp_valid asserted while in LOAD
// BEHAVIOUR
//  Reset: state=LOAD, load pointer=0, load_ready=1 after release, gray_ready=0, rd_data=0, rd_valid=0,
//   done=0, wr_count=0, all err_*=0. Memories are not reset; reset mid-operation restarts at LOAD.
//  FSM LOAD -> SERVE -> DONE; DONE exits only by reset.
//  LOAD: each accepted beat writes gray_mem[ptr]=load_data, clears lbp_mem[ptr]=0 and written[ptr]=0,
//   ptr++. Beat at ptr = 2^ADDR_W-1 -> SERVE next cycle; load_ready low and gray_ready high that cycle.
//   gray_req in LOAD: gray_data=0, err_proto set. lbp_valid in LOAD: ignored, err_proto set.
//  SERVE: gray_data combinational from gray_addr (initiator samples it the cycle after it drives the
//   address); gray_mem read-only. lbp_valid: border address -> not stored, err_border set; else
//   lbp_mem[addr]=lbp_data, written[addr]=1, wr_count++; if written[addr] was already 1, value
//   overwritten and err_dup set. finish high -> DONE next cycle; write in the same cycle still stored.
//  DONE: gray_ready=0, gray_data=0 regardless of gray_req; lbp_valid ignored (no flag). rd_en ->
//   rd_data=lbp_mem[rd_addr], rd_valid=1 next cycle; back-to-back rd_en gives 1 result/cycle.
//   rd_en outside DONE ignored, rd_valid stays 0.
//  wr_count saturates at all-ones. Expected full run: (2^LOG2_DIM-2)^2 = 15876 writes, no errors.
// TESTING
//  1 load mem[a]=a[7:0] for 16384 beats -> load_ready 0, gray_ready 1 cycle after last beat; beat 16385 not accepted.
//  2 SERVE, gray_req=1 gray_addr=0x0081 -> gray_data=0x81 same cycle; gray_req=0 -> 0x00.
//  3 lbp write 0x0081<-0xA5, finish -> done=1; rd_en 0x0081 -> rd_data=0xA5, rd_valid next cycle; wr_count=1.
//  4 write 0x0000<-0x11 -> err_border=1, wr_count unchanged, readback 0x00; rewrite 0x0081<-0x5A -> err_dup=1, readback 0x5A.
//  5 full run with LBP initiator on random image -> done, wr_count=15876, no err, all codes match golden model.
//  6 reset asserted mid-SERVE -> gray_ready=0 immediately; after release load_ready=1, flags/wr_count 0, reload OK.

Source files
------------

// File: rtl/lbp_image_host.sv
// -----------------------------------------------------------------------------
// lbp_image_host
//
// Purpose:
//   Host/responder end of the LBP gray-read / lbp-write interface.
//   The block:
//     - loads a square gray image in raster order through a valid/ready port,
//     - serves initiator pixel reads with zero-latency (combinational) data,
//     - captures LBP result writes into a result memory and counts them,
//     - flags border writes, duplicate writes and protocol misuse,
//     - once finish is seen, exposes the result image through a registered
//       readback port.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   load_valid/load_data/
//   load_ready                 pixel load stream, address implicit from 0
//   gray_addr/gray_req/
//   gray_ready/gray_data       initiator pixel read port (gray_data combinational)
//   lbp_addr/lbp_valid/
//   lbp_data                   initiator result write port
//   finish                     initiator done strobe
//   rd_en/rd_addr/rd_data/
//   rd_valid                   result readback (DONE only, one-cycle latency)
//   done                       high in DONE
//   wr_count                   number of stored result writes (saturating)
//   err_border/err_dup/
//   err_proto                  sticky error flags
// -----------------------------------------------------------------------------
module lbp_image_host #(
  parameter  int LOG2_DIM = 7,
  parameter  int DATA_W   = 8,
  localparam int ADDR_W   = 2 * LOG2_DIM
) (
  input  logic              clk,
  input  logic              reset,
  // image load stream
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  // initiator gray read port
  input  logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_req,
  output logic              gray_ready,
  output logic [DATA_W-1:0] gray_data,
  // initiator LBP write port
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              lbp_valid,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  // result readback
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  // status
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_border,
  output logic              err_dup,
  output logic              err_proto
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [LOG2_DIM-1:0] EDGE_MAX = '1;
  localparam logic [ADDR_W-1:0]   PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]     CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Storage (not reset; the load pass initialises every entry)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] gray_mem    [DEPTH];
  logic [DATA_W-1:0] lbp_mem     [DEPTH];
  logic              written_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [ADDR_W-1:0] load_ptr_reg;
  logic [ADDR_W:0]   wr_count_reg;
  logic              err_border_reg;
  logic              err_dup_reg;
  logic              err_proto_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;

  logic in_load;
  logic in_serve;
  logic in_done;
  logic load_fire;
  logic lbp_border;
  logic lbp_store;
  logic lbp_dup;
  logic rd_fire;

  logic [LOG2_DIM-1:0] lbp_x;
  logic [LOG2_DIM-1:0] lbp_y;

  // Shared write port into lbp_mem / written_mem: the load pass clears
  // entries, the serve phase stores results. The two phases never overlap.
  logic              res_we;
  logic [ADDR_W-1:0] res_waddr;
  logic [DATA_W-1:0] res_wdata;
  logic              res_wflag;

  assign in_load  = (state_reg == ST_LOAD);
  assign in_serve = (state_reg == ST_SERVE);
  assign in_done  = (state_reg == ST_DONE);

  assign load_fire = in_load && load_valid;
  assign rd_fire   = in_done && rd_en;

  assign lbp_x = lbp_addr[LOG2_DIM-1:0];
  assign lbp_y = lbp_addr[ADDR_W-1:LOG2_DIM];

  // Border pixels have no full 3x3 neighbourhood, so no LBP code exists there.
  assign lbp_border = (lbp_x == '0) || (lbp_x == EDGE_MAX) ||
                      (lbp_y == '0) || (lbp_y == EDGE_MAX);

  assign lbp_store = in_serve && lbp_valid && !lbp_border;
  assign lbp_dup   = lbp_store && written_mem[lbp_addr];

  assign res_we    = load_fire || lbp_store;
  assign res_waddr = in_load ? load_ptr_reg : lbp_addr;
  assign res_wdata = in_load ? '0 : lbp_data;
  assign res_wflag = !in_load;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: begin
        if (load_fire && (load_ptr_reg == '1)) begin
          state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (finish) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_LOAD;
      load_ptr_reg   <= '0;
      wr_count_reg   <= '0;
      err_border_reg <= 1'b0;
      err_dup_reg    <= 1'b0;
      err_proto_reg  <= 1'b0;
      rd_valid_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (load_fire) begin
        load_ptr_reg <= load_ptr_reg + PTR_ONE;
      end

      // Saturate rather than wrap so a runaway initiator cannot alias to a
      // plausible count.
      if (lbp_store && (wr_count_reg != '1)) begin
        wr_count_reg <= wr_count_reg + CNT_ONE;
      end

      if (in_load && (gray_req || lbp_valid)) begin
        err_proto_reg <= 1'b1;
      end

      if (in_serve && lbp_valid && lbp_border) begin
        err_border_reg <= 1'b1;
      end

      if (lbp_dup) begin
        err_dup_reg <= 1'b1;
      end

      rd_valid_reg <= rd_fire;
    end
  end

  // ---------------------------------------------------------------------------
  // Memories
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_fire) begin
      gray_mem[load_ptr_reg] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (res_we) begin
      lbp_mem[res_waddr]     <= res_wdata;
      written_mem[res_waddr] <= res_wflag;
    end
  end

  // Registered readback; the value holds between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_fire) begin
      rd_data_reg <= lbp_mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The initiator samples gray_data in the cycle after it drives the address,
  // so the read path is purely combinational.
  assign gray_data  = (in_serve && gray_req) ? gray_mem[gray_addr] : '0;

  assign load_ready = in_load;
  assign gray_ready = in_serve;
  assign done       = in_done;
  assign wr_count   = wr_count_reg;
  assign err_border = err_border_reg;
  assign err_dup    = err_dup_reg;
  assign err_proto  = err_proto_reg;
  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;

endmodule

// File: tb/tb_lbp_image_host.sv
// -----------------------------------------------------------------------------
// tb_lbp_image_host
//
// Self-checking bench for lbp_image_host. A behavioural model (phase, image,
// result array, written bits, counters) is updated from the DUT inputs on each
// rising edge; a compare process checks every DUT output against it on each
// falling edge. Directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_lbp_image_host;

  localparam int LOG2_DIM = 7;
  localparam int N        = 1 << LOG2_DIM;
  localparam int DEPTH    = N * N;
  localparam int CNT_MAX  = (2 * DEPTH) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic [13:0] gray_addr = '0;
  logic        gray_req = 1'b0;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic [13:0] lbp_addr = '0;
  logic        lbp_valid = 1'b0;
  logic [7:0]  lbp_data = '0;
  logic        finish = 1'b0;
  logic        rd_en = 1'b0;
  logic [13:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;
  logic [14:0] wr_count;
  logic        err_border;
  logic        err_dup;
  logic        err_proto;

  lbp_image_host #(.LOG2_DIM(LOG2_DIM), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .lbp_addr   (lbp_addr),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .wr_count   (wr_count),
    .err_border (err_border),
    .err_dup    (err_dup),
    .err_proto  (err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: 0 = loading, 1 = serving, 2 = finished
  // ---------------------------------------------------------------------------
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  bit         m_eb = 0, m_ed = 0, m_ep = 0;
  bit         m_rdv = 0;
  logic [7:0] m_rdd = '0;
  logic [7:0] m_img [DEPTH];
  logic [7:0] m_lbp [DEPTH];
  bit         m_wr  [DEPTH];

  function automatic bit is_border(input int a);
    int x, y;
    x = a % N;
    y = a / N;
    return (x == 0) || (y == 0) || (x == N - 1) || (y == N - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0;
      m_eb = 0; m_ed = 0; m_ep = 0;
      m_rdv = 0; m_rdd = '0;
    end else begin
      m_rdv = 0;
      if (m_phase == 0) begin
        if (gray_req || lbp_valid) m_ep = 1;
        if (load_valid) begin
          m_img[m_ptr] = load_data;
          m_lbp[m_ptr] = 8'h00;
          m_wr[m_ptr]  = 0;
          if (m_ptr == DEPTH - 1) m_phase = 1;
          m_ptr = (m_ptr + 1) % DEPTH;
        end
      end else if (m_phase == 1) begin
        if (lbp_valid) begin
          if (is_border(int'(lbp_addr))) begin
            m_eb = 1;
          end else begin
            if (m_wr[lbp_addr]) m_ed = 1;
            m_wr[lbp_addr]  = 1;
            m_lbp[lbp_addr] = lbp_data;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
          end
        end
        if (finish) m_phase = 2;
      end else begin
        if (rd_en) begin
          m_rdv = 1;
          m_rdd = m_lbp[rd_addr];
        end
      end
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("load_ready", 32'(load_ready), 32'(m_phase == 0));
    chk("gray_ready", 32'(gray_ready), 32'(m_phase == 1));
    chk("done",       32'(done),       32'(m_phase == 2));
    chk("gray_data",  32'(gray_data),  (m_phase == 1 && gray_req) ? 32'(m_img[gray_addr]) : 32'h0);
    chk("wr_count",   32'(wr_count),   32'(m_cnt));
    chk("err_border", 32'(err_border), 32'(m_eb));
    chk("err_dup",    32'(err_dup),    32'(m_ed));
    chk("err_proto",  32'(err_proto),  32'(m_ep));
    chk("rd_valid",   32'(rd_valid),   32'(m_rdv));
    chk("rd_data",    32'(rd_data),    32'(m_rdd));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [7:0] img [DEPTH];   // image as the bench loads it (golden source)

  // LBP code: bit k set when neighbour k >= centre, neighbours in raster order.
  function automatic logic [7:0] golden(input int a);
    int dys[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dxs[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int x, y;
    logic [7:0] c, code;
    if (is_border(a)) return 8'h00;
    x = a % N;
    y = a / N;
    c = img[a];
    code = '0;
    for (int k = 0; k < 8; k++) begin
      if (img[(y + dys[k]) * N + (x + dxs[k])] >= c) code[k] = 1'b1;
    end
    return code;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit random_img);
    for (int a = 0; a < DEPTH; a++) begin
      if (random_img && ($urandom_range(0, 15) == 0)) begin
        load_valid = 1'b0;
        step();
      end
      img[a]     = random_img ? 8'($urandom) : a[7:0];
      load_valid = 1'b1;
      load_data  = img[a];
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_load_ready", 32'(load_ready), 32'h1);
    chk("reset_wr_count",   32'(wr_count),   32'h0);

    // Ramp image; last beat flips to SERVE, extra beat is not accepted.
    load_image(1'b0);
    chk("after_load_ready", 32'(load_ready), 32'h0);
    chk("after_gray_ready", 32'(gray_ready), 32'h1);
    chk("golden_pin_181",   32'(golden(32'h181)), 32'h10);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    step();
    load_valid = 1'b0;
    gray_req  = 1'b1;
    gray_addr = 14'h0000;
    #1 chk("extra_beat_ignored", 32'(gray_data), 32'h00);

    // Zero-latency read, and gating by gray_req.
    gray_addr = 14'h0081;
    #1 chk("gray_0081", 32'(gray_data), 32'h81);
    gray_req = 1'b0;
    #1 chk("gray_req_low", 32'(gray_data), 32'h00);

    // Readback request outside DONE is ignored (model checks rd_valid).
    rd_en   = 1'b1;
    rd_addr = 14'h0081;
    step();
    rd_en = 1'b0;
    chk("rd_en_in_serve", 32'(rd_valid), 32'h0);

    // Result writes: stored, border, second address, duplicate with finish.
    lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'hA5;
    step();
    chk("wr_count_1", 32'(wr_count), 32'h1);
    lbp_addr = 14'h0000; lbp_data = 8'h11;
    step();
    chk("err_border_set",   32'(err_border), 32'h1);
    chk("wr_count_border",  32'(wr_count),   32'h1);
    lbp_addr = 14'h0181; lbp_data = 8'hC3;
    step();
    lbp_addr = 14'h0081; lbp_data = 8'h5A; finish = 1'b1;
    step();
    finish = 1'b0;
    chk("done_set",    32'(done),     32'h1);
    chk("err_dup_set", 32'(err_dup),  32'h1);
    chk("wr_count_3",  32'(wr_count), 32'h3);
    lbp_addr = 14'h0181; lbp_data = 8'hFF;       // ignored in DONE
    gray_req = 1'b1;
    #1 chk("gray_in_done", 32'(gray_data), 32'h00);
    step();
    lbp_valid = 1'b0;
    gray_req  = 1'b0;
    chk("wr_count_done", 32'(wr_count), 32'h3);

    // Back-to-back readback.
    rd_en = 1'b1; rd_addr = 14'h0181;
    step();
    chk("rb_0181", 32'(rd_data), 32'hC3);
    chk("rb_valid", 32'(rd_valid), 32'h1);
    rd_addr = 14'h0081;
    step();
    chk("rb_0081", 32'(rd_data), 32'h5A);
    rd_addr = 14'h0000;
    step();
    chk("rb_0000", 32'(rd_data), 32'h00);
    rd_en = 1'b0;
    step();
    chk("rb_idle", 32'(rd_valid), 32'h0);

    // Random image, then reset in the middle of SERVE.
    pulse_reset();
    load_image(1'b1);
    for (int i = 0; i < 8; i++) begin
      gray_req  = 1'b1;
      gray_addr = 14'($urandom);
      lbp_valid = 1'b1;
      lbp_addr  = 14'(((i + 1) * N) + 5);
      lbp_data  = 8'($urandom);
      step();
    end
    reset = 1'b1;
    #1 chk("reset_gray_ready", 32'(gray_ready), 32'h0);
    gray_req  = 1'b0;
    lbp_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rel_load_ready", 32'(load_ready), 32'h1);
    chk("rel_wr_count",   32'(wr_count),   32'h0);
    chk("rel_err_dup",    32'(err_dup),    32'h0);

    // Protocol misuse during LOAD.
    gray_req  = 1'b1;
    gray_addr = 14'h0081;
    #1 chk("gray_in_load", 32'(gray_data), 32'h00);
    step();
    gray_req = 1'b0;
    chk("err_proto_set", 32'(err_proto), 32'h1);
    pulse_reset();
    chk("proto_cleared", 32'(err_proto), 32'h0);

    // Full run on a fresh random image.
    load_image(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      gray_req  = 1'($urandom);
      gray_addr = 14'($urandom);
      lbp_valid = !is_border(i);
      lbp_addr  = i[13:0];
      lbp_data  = golden(i);
      finish    = (i == DEPTH - 1);
      step();
    end
    gray_req  = 1'b0;
    lbp_valid = 1'b0;
    finish    = 1'b0;
    chk("full_done",     32'(done),     32'h1);
    chk("full_wr_count", 32'(wr_count), 32'd15876);
    chk("full_err",      32'({err_border, err_dup, err_proto}), 32'h0);

    for (int a = 0; a < DEPTH; a++) begin
      if ($urandom_range(0, 7) == 0) begin
        rd_en = 1'b0;
        step();
      end
      rd_en   = 1'b1;
      rd_addr = a[13:0];
      step();
      chk("full_readback", 32'(rd_data), 32'(golden(a)));
    end
    rd_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
